// File: rtl/byte_ram_dp.sv
// byte_ram_dp: dual-port word RAM with per-byte write enables and a built-in clear engine.
//
// Port A (CPU): synchronous read/write, byte-lane write enables, 1-cycle registered read.
//   RD_MODE selects read-during-write behaviour: 0 = old word, 1 = old word merged with
//   the lanes being written.
// Port B (display): read-only, 1-cycle registered read, always returns the old word.
// Clear engine: walks every address writing FILL_VALUE, one word per cycle, after reset
//   (if CLEAR_ON_RESET) or after a clr pulse. Port A writes are dropped while busy.
//
// Ports:
//   clk        single clock for both ports and the clear engine
//   rst        synchronous active-high reset
//   we         port A write strobe
//   sel        port A byte-lane enables (lane i = d[8i+7:8i])
//   addr       port A word address
//   d          port A write data, lane-aligned
//   q          port A registered read data
//   dispAddr   port B word address
//   dispColor  port B registered read data
//   clr        single-cycle request to start a clear
//   busy       clear engine active
module byte_ram_dp #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RD_MODE        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [DATA_WIDTH/8-1:0]   sel,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     d,
    output logic [DATA_WIDTH-1:0]     q,
    input  logic [ADDR_WIDTH-1:0]     dispAddr,
    output logic [DATA_WIDTH-1:0]     dispColor,
    input  logic                      clr,
    output logic                      busy
);

    localparam int unsigned LANES = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        StIdle  = 1'b0,
        StClear = 1'b1
    } state_e;

    state_e                  state_q;
    logic                    busy_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic [DATA_WIDTH-1:0]   q_q;
    logic [DATA_WIDTH-1:0]   q_d;
    logic [DATA_WIDTH-1:0]   disp_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    a_wr;
    logic                    clr_wr;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   merged;

    // Port A may only write while the clear engine is idle; nothing writes during reset.
    assign a_wr   = we && (state_q == StIdle) && !rst;
    assign clr_wr = (state_q == StClear) && !rst;

    always_comb begin
        rd_word = mem_q[addr];
        merged  = rd_word;
        for (int i = 0; i < LANES; i++) begin
            if (sel[i]) begin
                merged[8*i +: 8] = d[8*i +: 8];
            end
        end
        // Write-first only when a write actually lands this cycle.
        q_d = ((RD_MODE != 0) && a_wr) ? merged : rd_word;
    end

    // Memory array: no reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem_q[cnt_q] <= FILL_VALUE;
        end else if (a_wr) begin
            for (int i = 0; i < LANES; i++) begin
                if (sel[i]) begin
                    mem_q[addr][8*i +: 8] <= d[8*i +: 8];
                end
            end
        end
    end

    // Read registers and clear FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            disp_q <= '0;
            cnt_q  <= '0;
            if (CLEAR_ON_RESET != 0) begin
                state_q <= StClear;
                busy_q  <= 1'b1;
            end else begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end
        end else begin
            q_q    <= q_d;
            disp_q <= mem_q[dispAddr];
            case (state_q)
                StIdle: begin
                    if (clr) begin
                        state_q <= StClear;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                StClear: begin
                    // clr is ignored here; the sweep always runs to the last word.
                    if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q         = q_q;
    assign dispColor = disp_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_byte_ram_dp.sv
// Testbench for byte_ram_dp. Two instances share stimulus:
//   dut0: RD_MODE=0, CLEAR_ON_RESET=1, FILL_VALUE=0
//   dut1: RD_MODE=1, CLEAR_ON_RESET=0, FILL_VALUE=A5A5A5A5
// A driver pushes expected outputs from a reference model; a monitor pops and compares.
module tb_byte_ram_dp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [3:0]  sel = '0;
    logic [3:0]  addr = '0;
    logic [31:0] d = '0;
    logic [3:0]  dispAddr = '0;
    logic        clr = 1'b0;

    logic [31:0] q0, q1, dc0, dc1;
    logic        busy0, busy1;

    always #5 clk = ~clk;

    byte_ram_dp #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_MODE(0), .CLEAR_ON_RESET(1),
        .FILL_VALUE(32'h0000_0000)
    ) u_dut0 (
        .clk(clk), .rst(rst), .we(we), .sel(sel), .addr(addr), .d(d), .q(q0),
        .dispAddr(dispAddr), .dispColor(dc0), .clr(clr), .busy(busy0)
    );

    byte_ram_dp #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_MODE(1), .CLEAR_ON_RESET(0),
        .FILL_VALUE(32'hA5A5_A5A5)
    ) u_dut1 (
        .clk(clk), .rst(rst), .we(we), .sel(sel), .addr(addr), .d(d), .q(q1),
        .dispAddr(dispAddr), .dispColor(dc1), .clr(clr), .busy(busy1)
    );

    // Reference model: memory image, which words hold a defined value, words left to clear.
    int unsigned rm_c   [2] = '{0, 1};
    int unsigned cor_c  [2] = '{1, 0};
    logic [31:0] fill_c [2] = '{32'h0000_0000, 32'hA5A5_A5A5};
    logic [31:0] mmem   [2][16];
    bit          mknown [2][16];
    int          mrem   [2];

    typedef struct {
        logic [31:0] q0, q1, d0, d1;
        logic        b0, b1;
        bit          vq0, vq1, vd0, vd1;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic model_step(input int k, input logic r, input logic w, input logic [3:0] s,
                              input logic [3:0] a, input logic [31:0] dd, input logic c,
                              input logic [3:0] da, output logic [31:0] eq,
                              output logic [31:0] ed, output bit vq, output bit vd,
                              output logic eb);
        logic [31:0] old;
        logic [31:0] merged;
        bit          wr;
        if (r) begin
            eq = '0; ed = '0; vq = 1'b1; vd = 1'b1;
            mrem[k] = (cor_c[k] != 0) ? 16 : 0;
        end else begin
            old = mmem[k][a];
            wr  = (mrem[k] == 0) && w;
            merged = old;
            for (int b = 0; b < 4; b++) begin
                if (s[b]) merged[8*b +: 8] = dd[8*b +: 8];
            end
            if (rm_c[k] != 0 && wr) begin
                eq = merged;
                vq = mknown[k][a] || (s == 4'hF);
            end else begin
                eq = old;
                vq = mknown[k][a];
            end
            ed = mmem[k][da];
            vd = mknown[k][da];
            if (mrem[k] > 0) begin
                mmem[k][16 - mrem[k]]   = fill_c[k];
                mknown[k][16 - mrem[k]] = 1'b1;
                mrem[k]--;
            end else begin
                if (wr) begin
                    mmem[k][a] = merged;
                    if (s == 4'hF) mknown[k][a] = 1'b1;
                end
                if (c) mrem[k] = 16;
            end
        end
        eb = (mrem[k] > 0);
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next posedge.
    task automatic cyc(input logic r, input logic w, input logic [3:0] s, input logic [3:0] a,
                       input logic [31:0] dd, input logic c, input logic [3:0] da);
        exp_t e;
        @(negedge clk);
        rst = r; we = w; sel = s; addr = a; d = dd; clr = c; dispAddr = da;
        model_step(0, r, w, s, a, dd, c, da, e.q0, e.d0, e.vq0, e.vd0, e.b0);
        model_step(1, r, w, s, a, dd, c, da, e.q1, e.d1, e.vq1, e.vd1, e.b1);
        sb.push_back(e);
    endtask

    task automatic rd(input logic [3:0] a);
        cyc(1'b0, 1'b0, 4'h0, a, $urandom, 1'b0, a);
    endtask

    task automatic wr(input logic [3:0] s, input logic [3:0] a, input logic [31:0] dd);
        cyc(1'b0, 1'b1, s, a, dd, 1'b0, 4'($urandom_range(0, 15)));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("busy0", {31'b0, busy0}, {31'b0, e.b0});
                check("busy1", {31'b0, busy1}, {31'b0, e.b1});
                if (e.vq0) check("q0", q0, e.q0);
                if (e.vq1) check("q1", q1, e.q1);
                if (e.vd0) check("dispColor0", dc0, e.d0);
                if (e.vd1) check("dispColor1", dc1, e.d1);
            end
        end
    end

    initial begin
        int guard;
        for (int k = 0; k < 2; k++) begin
            mrem[k] = 0;
            for (int i = 0; i < 16; i++) mknown[k][i] = 1'b0;
        end

        // Reset for two cycles (writes attempted during reset must be dropped).
        cyc(1'b1, 1'b1, 4'hF, 4'h2, 32'hFFFF_FFFF, 1'b0, 4'h2);
        cyc(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0);
        for (int i = 0; i < 20; i++) rd(4'(i));
        // dut0 is idle again; this clear fills both instances.
        cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0);
        for (int i = 0; i < 17; i++) rd(4'(i));
        for (int i = 0; i < 16; i++) rd(4'(i));

        // Byte-lane writes.
        wr(4'hF, 4'h3, 32'h1122_3344);
        wr(4'h1, 4'h3, 32'h0000_00AA);
        wr(4'h2, 4'h3, 32'h0000_BB00);
        rd(4'h3);
        wr(4'h0, 4'h3, $urandom);
        rd(4'h3);
        rd(4'h3);

        // Read-during-write at address 5.
        wr(4'hF, 4'h5, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b1, 4'hC, 4'h5, 32'h1234_0000, 1'b0, 4'h5);
        rd(4'h5);
        rd(4'h5);

        // clr mid-run with a dropped write and an ignored second clr.
        for (int i = 0; i < 16; i++) wr(4'hF, 4'(i), $urandom | 32'h1);
        cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0);
        for (int j = 0; j < 18; j++) begin
            if (j == 3) wr(4'hF, 4'h7, 32'hFFFF_FFFF);
            else if (j == 6) cyc(1'b0, 1'b0, 4'h0, 4'h7, 32'h0, 1'b1, 4'h7);
            else rd(4'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 16; i++) rd(4'(i));

        // Reset arriving after eight clear writes.
        for (int i = 0; i < 16; i++) wr(4'hF, 4'(i), $urandom | 32'h100);
        cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0);
        for (int j = 0; j < 8; j++) rd(4'(j));
        cyc(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
        for (int j = 0; j < 18; j++) rd(4'(j));
        for (int i = 0; i < 16; i++) rd(4'(i));

        // Randomized traffic with occasional clr and rst.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 1) == 1),
                4'($urandom), 4'($urandom), $urandom,
                ($urandom_range(0, 39) == 0), 4'($urandom));
        end
        rd(4'h0);
        rd(4'h1);

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
